// File: rtl/rom_boot_loader.sv
// ROM responder for the instruction/rodata arbiter.
// Boots its word array from a byte stream: length, payload, checksum.
module rom_boot_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int RODATA_BIT  = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_data_i,
  output logic                  load_ready_o,
  output logic                  boot_done_o,
  output logic                  boot_err_o
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int WCW = AW + 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [7:0]            sum_q, sum_d;
  logic [23:0]           asm_q, asm_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [AW-1:0]         ridx;
  logic                  accept;
  logic [15:0]           n_full;
  logic                  unused_addr;

  assign ridx = {mem_addr_i[RODATA_BIT], mem_addr_i[AW:2]};
  assign unused_addr = ^mem_addr_i;

  assign load_ready_o = (state_q != S_DONE) && (state_q != S_ERR);
  assign boot_done_o  = (state_q == S_DONE);
  assign boot_err_o   = (state_q == S_ERR);
  assign mem_data_o   = mem_data_q;

  assign accept = load_valid_i && load_ready_o;
  assign n_full = {load_data_i, len_q[7:0]};
  assign waddr  = word_cnt_q[AW-1:0];
  assign wdata  = {load_data_i, asm_q};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    sum_d      = sum_q;
    asm_d      = asm_q;
    we         = 1'b0;
    unique case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = load_data_i;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d      = n_full;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          sum_d      = '0;
          if (n_full == 16'd0 || {1'b0, n_full} > DEPTH_L)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d      = sum_q + load_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: asm_d[7:0]   = load_data_i;
            2'd1: asm_d[15:8]  = load_data_i;
            2'd2: asm_d[23:16] = load_data_i;
            default: begin
              we         = 1'b1;
              word_cnt_d = word_cnt_q + 1'b1;
              if (16'(word_cnt_q) + 16'd1 == len_q)
                state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept)
          state_d = (sum_q + load_data_i == 8'h00) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  // reads stay gated to zero until the image is accepted
  always_comb begin
    mem_data_d = mem_data_q;
    if (mem_req_i)
      mem_data_d = (state_q == S_DONE) ? mem[ridx] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LEN0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
      asm_q      <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      sum_q      <= sum_d;
      asm_q      <= asm_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: random boot images with gaps,
// checked against a byte-stream parsing model.
module tb_rom_boot_loader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        boot_done;
  logic        boot_err;

  always #5 clk = ~clk;

  rom_boot_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .mem_req_i    (mem_req),
    .mem_addr_i   (mem_addr),
    .mem_data_o   (mem_data),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .boot_done_o  (boot_done),
    .boot_err_o   (boot_err)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  bit          gaps = 1'b1;
  logic [31:0] ref_mem [4096];
  int          ref_st = 0;
  logic [7:0]  img [$];
  logic [31:0] wds [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // model: 0 = still loading, 1 = accepted, 2 = rejected
  function automatic void model(input logic [7:0] s [$]);
    int n, sum;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n == 0 || n > 4096) begin
      ref_st = 2;
      return;
    end
    sum = 0;
    for (int w = 0; w < n; w++) begin
      ref_mem[w] = 0;
      for (int b = 0; b < 4; b++) begin
        ref_mem[w] = ref_mem[w] + (32'(s[2 + 4*w + b]) << (8*b));
        sum = sum + int'(s[2 + 4*w + b]);
      end
    end
    sum = sum + int'(s[2 + 4*n]);
    ref_st = (sum % 256 == 0) ? 1 : 2;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 20) & 1) * 2048 + int'((a >> 2) % 2048);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (ref_st == 1) ? ref_mem[idx_of(a)] : 32'h0;
  endfunction

  task automatic build(input bit bad);
    int n, sum;
    logic [7:0] c;
    n = wds.size();
    img = {};
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    sum = 0;
    foreach (wds[i])
      for (int b = 0; b < 4; b++) begin
        img.push_back(8'(wds[i] >> (8*b)));
        sum = sum + int'(8'(wds[i] >> (8*b)));
      end
    c = 8'((256 - sum % 256) % 256);
    if (bad) c = c + 8'd1;
    img.push_back(c);
  endtask

  task automatic send(input logic [7:0] b);
    while (gaps && $urandom_range(3) == 0) @(negedge clk);
    load_valid = 1'b1;
    load_data  = b;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 8'($urandom);
  endtask

  task automatic load_img(input string tag);
    for (int i = 0; i < img.size() - 1; i++) send(img[i]);
    chk({tag, "_pre_done"}, 32'(boot_done), 32'(0));
    chk({tag, "_pre_err"}, 32'(boot_err), 32'(0));
    send(img[img.size() - 1]);
    model(img);
    chk({tag, "_done"}, 32'(boot_done), 32'(ref_st == 1));
    chk({tag, "_err"}, 32'(boot_err), 32'(ref_st == 2));
    chk({tag, "_ready"}, 32'(load_ready), 32'(ref_st == 0));
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    mem_req  = 1'b1;
    mem_addr = a;
    @(negedge clk);
    mem_req  = 1'b0;
    mem_addr = $urandom;
    chk(tag, mem_data, exp_rd(a));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    ref_st = 0;
    @(negedge clk);
  endtask

  task automatic image1(input bit bad);
    wds = {32'h13, 32'h6F};
    build(bad);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] last;
    repeat (2) @(negedge clk);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_ready", 32'(load_ready), 32'(1));
    chk("rst_done", 32'(boot_done), 32'(0));
    chk("rst_err", 32'(boot_err), 32'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    // image 1 and back-to-back reads
    rd("rd_pre_done", 32'h0);
    image1(1'b0);
    load_img("img1");
    rd("img1_rd0", 32'h0);
    rd("img1_rd4", 32'h4);
    chk("img1_lit0", exp_rd(32'h0), 32'h13);
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 1) ? 32'h4 : 32'h0;
      mem_req  = 1'b1;
      mem_addr = a;
      @(negedge clk);
      chk("b2b", mem_data, exp_rd(a));
      last = exp_rd(a);
    end
    mem_req = 1'b0;
    @(negedge clk);
    chk("idle_hold", mem_data, last);

    // bad checksum
    do_reset();
    image1(1'b1);
    load_img("badcs");
    rd("badcs_rd", 32'h0);

    // length limits
    do_reset();
    img = {8'h00, 8'h00};
    load_img("len0");
    do_reset();
    img = {8'h01, 8'h10};
    load_img("len4097");
    do_reset();
    wds = {};
    for (int i = 0; i < 4096; i++) wds.push_back($urandom);
    build(1'b0);
    load_img("full");
    for (int i = 0; i < 8; i++) rd("full_rd", $urandom);
    rd("full_top", 32'h0010_1FFC);

    // rodata half and aliasing
    do_reset();
    wds = {};
    for (int i = 0; i < 2049; i++) wds.push_back($urandom);
    wds[0] = 32'h93;
    wds[2048] = 32'hDEADBEEF;
    build(1'b0);
    load_img("ro");
    rd("ro_hi", 32'h0010_0000);
    rd("ro_lo", 32'h0);
    rd("ro_alias", 32'h0000_2000);
    chk("ro_lit", exp_rd(32'h0010_0000), 32'hDEADBEEF);

    // in-flight read dropped by reset
    do_reset();
    image1(1'b0);
    load_img("fl");
    rd("fl_rd4", 32'h4);
    mem_req  = 1'b1;
    mem_addr = 32'h0;
    #2 rst_ni = 1'b0;
    #1 chk("fl_drop", mem_data, 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    ref_st = 0;
    @(negedge clk);

    // reset mid-DATA, then re-stream
    image1(1'b0);
    for (int i = 0; i < 5; i++) send(img[i]);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_ready", 32'(load_ready), 32'(1));
    chk("mid_done", 32'(boot_done), 32'(0));
    chk("mid_err", 32'(boot_err), 32'(0));
    chk("mid_data", mem_data, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    ref_st = 0;
    @(negedge clk);
    load_img("re");
    rd("re_rd0", 32'h0);
    rd("re_rd4", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
